// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared state encoding and width helpers for the HyperBus arbiter
package hyperbus_pkg;

    localparam int NSTATES = 4;

    localparam logic [NSTATES-1:0] ST_IDLE_OH    = 4'b0001;
    localparam logic [NSTATES-1:0] ST_WAIT_WR_OH = 4'b0010;
    localparam logic [NSTATES-1:0] ST_WAIT_RD_OH = 4'b0100;
    localparam logic [NSTATES-1:0] ST_RELEASE_OH = 4'b1000;

    typedef enum logic [NSTATES-1:0] {
        ST_IDLE    = ST_IDLE_OH,
        ST_WAIT_WR = ST_WAIT_WR_OH,
        ST_WAIT_RD = ST_WAIT_RD_OH,
        ST_RELEASE = ST_RELEASE_OH
    } hb_state_e;

    // Watchdog counter width; never below one bit so a disabled watchdog still elaborates.
    function automatic int hb_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int HB_TIMEOUT_DEFAULT = 1024;
    localparam int HB_TIMEOUT_W       = hb_cnt_width(HB_TIMEOUT_DEFAULT);

endpackage

// File: rtl/hyperbus_rr_pick.sv
// rtl/hyperbus_rr_pick.sv - combinational round-robin selector starting after the last winner
module hyperbus_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  pick,
    output logic             any
);

    // Walk the requesters cyclically from last+1; the first pending one wins.
    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && pending[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/hyperbus_arbiter.sv
// rtl/hyperbus_arbiter.sv - round-robin arbiter sharing the hyperbus_fifo word port with a watchdog
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst,
    input  logic [NREQ-1:0]            req_rrq,
    input  logic [NREQ-1:0]            req_wrq,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_adr_i,
    input  logic [NREQ*DATA_WIDTH-1:0] req_dat_i,
    output logic [DATA_WIDTH-1:0]      req_dat_o,
    output logic [NREQ-1:0]            req_done,
    output logic [NREQ-1:0]            req_err,
    output logic                       busy,
    output logic [NREQ-1:0]            grant,
    output logic                       rrq,
    output logic                       wrq,
    output logic [ADDR_WIDTH-1:0]      adr_o,
    output logic [DATA_WIDTH-1:0]      tx_dat_o,
    input  logic [DATA_WIDTH-1:0]      rx_dat_i,
    input  logic                       tx_ready,
    input  logic                       rx_valid
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = hb_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    hb_state_e              state_q, state_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rrq_q, rrq_d;
    logic                   wrq_q, wrq_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic [NREQ-1:0]        err_q, err_d;

    logic [NREQ-1:0]        pick;
    logic                   any;
    logic                   timeout_hit;

    hyperbus_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (req_rrq | req_wrq),
        .last    (last_q),
        .pick    (pick),
        .any     (any)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LIMIT);

    // Next-state and next-register values; pulses default low, latches default to hold.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        adr_d   = adr_q;
        tx_d    = tx_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        rrq_d   = 1'b0;
        wrq_d   = 1'b0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick[i]) begin
                            adr_d  = req_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                            tx_d   = req_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                            last_d = IDX_W'(i);
                        end
                    end
                    // A requester asserting both read and write is served as a write.
                    if (|(pick & req_wrq)) begin
                        wrq_d   = 1'b1;
                        state_d = ST_WAIT_WR;
                    end else begin
                        rrq_d   = 1'b1;
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_WR: begin
                if (tx_ready) begin
                    done_d  = grant_q;
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    err_d   = grant_q;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RD: begin
                if (rx_valid) begin
                    rd_d    = rx_dat_i;
                    done_d  = grant_q;
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    err_d   = grant_q;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Dead cycle: the owner sees done/err and drops its level request.
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight silently.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            adr_q   <= '0;
            tx_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            rrq_q   <= 1'b0;
            wrq_q   <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            rrq_q   <= rrq_d;
            wrq_q   <= wrq_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign grant     = grant_q;
    assign rrq       = rrq_q;
    assign wrq       = wrq_q;
    assign adr_o     = adr_q;
    assign tx_dat_o  = tx_q;
    assign req_dat_o = rd_q;
    assign req_done  = done_q;
    assign req_err   = err_q;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb/tb_hyperbus_arbiter.sv - directed vector and sequence bench for hyperbus_arbiter
module tb_hyperbus_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic            wb_clk = 1'b0;
    logic            wb_rst;
    logic [NREQ-1:0] req_rrq, req_wrq;
    logic [NREQ*AW-1:0] req_adr_i;
    logic [NREQ*DW-1:0] req_dat_i;
    logic [DW-1:0]   req_dat_o;
    logic [NREQ-1:0] req_done, req_err, grant;
    logic            busy, rrq, wrq;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   tx_dat_o, rx_dat_i;
    logic            tx_ready, rx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    hyperbus_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .req_rrq(req_rrq), .req_wrq(req_wrq),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .req_dat_o(req_dat_o), .req_done(req_done), .req_err(req_err),
        .busy(busy), .grant(grant), .rrq(rrq), .wrq(wrq),
        .adr_o(adr_o), .tx_dat_o(tx_dat_o),
        .rx_dat_i(rx_dat_i), .tx_ready(tx_ready), .rx_valid(rx_valid)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic        rst;
        logic [1:0]  rq, wq;
        logic [31:0] a0, a1, d0, d1;
        logic        txr, rxv;
        logic [31:0] rxd;
        logic        e_busy;
        logic [1:0]  e_grant;
        logic        e_rrq, e_wrq;
        logic [31:0] e_adr, e_txd;
        logic [1:0]  e_done, e_err;
        logic [31:0] e_dato;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    function automatic logic [127:0] outs();
        return {23'd0, busy, grant, rrq, wrq, adr_o, tx_dat_o, req_done, req_err, req_dat_o};
    endfunction

    task automatic idle_inputs();
        req_rrq = '0; req_wrq = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_dat_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int           gcnt;
        int           gidx [6];
        int           gcyc [6];
        logic [1:0]   seen;

        wb_rst = 1'b1; idle_inputs(); req_adr_i = '0; req_dat_i = '0;

        vecs[0]  = '{1'b1, 2'd0, 2'd0, 32'h0,   32'h0,  32'h0,        32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'd0, 1'b0, 1'b0, 32'h0,   32'h0,        2'd0, 2'd0, 32'h0};
        vecs[1]  = '{1'b0, 2'd0, 2'd1, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b1, 2'd1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd0, 2'd0, 32'h0};
        for (int i = 2; i <= 5; i++)
            vecs[i] = '{1'b0, 2'd0, 2'd1, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0,
                        1'b1, 2'd1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 2'd0, 2'd0, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 2'd1, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 2'd1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 2'd1, 2'd0, 32'h0};
        vecs[7]  = '{1'b0, 2'd0, 2'd0, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'd0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 2'd0, 2'd0, 32'h0};
        vecs[8]  = '{1'b0, 2'd2, 2'd0, 32'h0,   32'h40, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0,
                     1'b1, 2'd2, 1'b1, 1'b0, 32'h40,  32'h0,        2'd0, 2'd0, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 2'd0, 32'h0,   32'h40, 32'h0,        32'h0, 1'b0, 1'b1, 32'h12345678,
                     1'b1, 2'd2, 1'b0, 1'b0, 32'h40,  32'h0,        2'd2, 2'd0, 32'h12345678};
        vecs[10] = '{1'b0, 2'd0, 2'd0, 32'h0,   32'h40, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'd0, 1'b0, 1'b0, 32'h40,  32'h0,        2'd0, 2'd0, 32'h12345678};
        vecs[11] = '{1'b0, 2'd0, 2'd0, 32'h0,   32'h0,  32'h0,        32'h0, 1'b1, 1'b1, 32'hFFFF,
                     1'b0, 2'd0, 1'b0, 1'b0, 32'h40,  32'h0,        2'd0, 2'd0, 32'h12345678};
        vecs[12] = '{1'b0, 2'd1, 2'd1, 32'h200, 32'h0,  32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b1, 2'd1, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 2'd0, 2'd0, 32'h12345678};
        vecs[13] = '{1'b0, 2'd1, 2'd1, 32'h200, 32'h0,  32'hCAFEF00D, 32'h0, 1'b1, 1'b1, 32'hAAAA,
                     1'b1, 2'd1, 1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 2'd1, 2'd0, 32'h12345678};
        vecs[14] = '{1'b0, 2'd0, 2'd0, 32'h0,   32'h0,  32'h0,        32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'd0, 1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 2'd0, 2'd0, 32'h12345678};

        // Table: reset, single write, single read, idle-ignores-responses, write-wins.
        for (int i = 0; i < 15; i++) begin
            wb_rst    = vecs[i].rst;
            req_rrq   = vecs[i].rq;
            req_wrq   = vecs[i].wq;
            req_adr_i = {vecs[i].a1, vecs[i].a0};
            req_dat_i = {vecs[i].d1, vecs[i].d0};
            tx_ready  = vecs[i].txr;
            rx_valid  = vecs[i].rxv;
            rx_dat_i  = vecs[i].rxd;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {23'd0, vecs[i].e_busy, vecs[i].e_grant, vecs[i].e_rrq, vecs[i].e_wrq,
                 vecs[i].e_adr, vecs[i].e_txd, vecs[i].e_done, vecs[i].e_err, vecs[i].e_dato});
        end

        // Round-robin from reset with a zero-latency FIFO.
        idle_inputs(); req_adr_i = '0; req_dat_i = '0;
        wb_rst = 1'b1; tick(); wb_rst = 1'b0;
        req_rrq = 2'b11; rx_valid = 1'b1; rx_dat_i = 32'h5A5A0001;
        gcnt = 0;
        for (int c = 0; c < 40 && gcnt < 6; c++) begin
            tick();
            if (rrq) begin
                gidx[gcnt] = grant[1] ? 1 : 0;
                gcyc[gcnt] = c;
                gcnt++;
            end
        end
        chk("rr_count", 128'(gcnt), 128'(6));
        for (int g = 0; g < gcnt; g++) begin
            chk($sformatf("rr_grant%0d", g), 128'(gidx[g]), 128'(g % 2));
            if (g > 0) chk($sformatf("rr_spacing%0d", g), 128'(gcyc[g] - gcyc[g-1]), 128'(3));
        end
        req_rrq = '0; tick();
        rx_valid = 1'b0; tick(); tick();
        chk("rr_end_idle", {126'd0, busy, |req_err}, 128'd0);
        chk("rr_dat", 128'(req_dat_o), 128'(32'h5A5A0001));

        // Timeout: no response, err after 16 WAIT edges, late response discarded.
        req_adr_i = {32'h0, 32'h80}; req_rrq = 2'b01;
        tick();
        chk("to_grant", {126'd0, rrq, grant[0]}, 128'b11);
        req_rrq = 2'b01;
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk($sformatf("to_k%0d", k), {124'd0, req_done, req_err},
                (k == TO) ? 128'b0001 : 128'b0000);
        end
        req_rrq = '0; tick(); tick();
        rx_valid = 1'b1; rx_dat_i = 32'hBAD0BAD0; tick();
        rx_valid = 1'b0;
        chk("to_late_ignored", {93'd0, busy, req_done, req_dat_o}, {93'd0, 1'b0, 2'b00, 32'h5A5A0001});

        // Same-edge race: response on the timeout edge wins.
        req_rrq = 2'b01; tick();
        chk("race_grant", 128'(rrq), 128'(1));
        for (int k = 1; k < TO; k++) tick();
        rx_valid = 1'b1; rx_dat_i = 32'h0F0F0F0F; tick();
        chk("race_done", {92'd0, req_done, req_err, req_dat_o}, {92'd0, 2'b01, 2'b00, 32'h0F0F0F0F});
        rx_valid = 1'b0; req_rrq = '0; tick(); tick();

        // Reset in WAIT_WR: everything cleared, no done, priority back to requester 0.
        req_adr_i = {32'h0, 32'h300}; req_dat_i = {32'h0, 32'h11112222}; req_wrq = 2'b01;
        tick();
        chk("rst_wr_grant", {126'd0, wrq, grant[0]}, 128'b11);
        tick(); tick();
        wb_rst = 1'b1; req_wrq = '0; tick();
        chk("rst_all_zero", outs(), 128'd0);
        wb_rst = 1'b0;
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen = seen | {|req_done, |req_err};
        end
        chk("rst_no_done", 128'(seen), 128'd0);
        req_adr_i = {32'h44, 32'h33}; req_rrq = 2'b11; tick();
        chk("rst_priority", {93'd0, rrq, grant, adr_o}, {93'd0, 1'b1, 2'b01, 32'h33});
        rx_valid = 1'b1; rx_dat_i = 32'h1; tick();
        chk("rst_after_done", 128'(req_done), 128'(2'b01));
        rx_valid = 1'b0; req_rrq = '0; tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
